// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the issue-stage hazard scoreboard:
// rollback-count width, register-index type and width helpers.
package hazard_scoreboard_pkg;

  localparam int DEFAULT_WAYS     = 4;
  localparam int DEFAULT_NUM_REGS = 32;

  localparam int ROLLBACK_WIDTH = $clog2(DEFAULT_WAYS + 1);
  localparam int RIDX_WIDTH     = $clog2(DEFAULT_NUM_REGS);

  typedef logic [RIDX_WIDTH-1:0] ridx_t;

  // Parametric forms used when a block is built with non-default sizes.
  function automatic int rollback_width(input int ways);
    return $clog2(ways + 1);
  endfunction

  function automatic int ridx_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/hz_way_check.sv
// Dependency check for one issue way: blocked when a used nonzero source is
// busy with a pending load, or is written by a valid older way in the bundle.
module hz_way_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int NUM_REGS = 32,
  parameter int WAY      = 0
) (
  input  logic                                valid,
  input  logic [ridx_width(NUM_REGS)-1:0]     rs1,
  input  logic [ridx_width(NUM_REGS)-1:0]     rs2,
  input  logic                                rs1_used,
  input  logic                                rs2_used,
  input  logic [NUM_REGS-1:0]                 busy_mask,
  input  logic [WAYS-1:0]                     older_valid,
  input  logic [WAYS*ridx_width(NUM_REGS)-1:0] older_dest,
  output logic                                blocked
);

  localparam int RW = ridx_width(NUM_REGS);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = rs1_used && (rs1 != '0) && busy_mask[rs1];
    rs2_hit = rs2_used && (rs2 != '0) && busy_mask[rs2];
    // Only ways below this one count; a nonzero dest match implies a nonzero source.
    for (int i = 0; i < WAYS; i++) begin
      if ((i < WAY) && older_valid[i] && (older_dest[i*RW +: RW] != '0)) begin
        if (rs1_used && (older_dest[i*RW +: RW] == rs1)) rs1_hit = 1'b1;
        if (rs2_used && (older_dest[i*RW +: RW] == rs2)) rs2_hit = 1'b1;
      end
    end
    blocked = valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register load-latency counters, in-order
// acceptance up to the first blocked way. Stats gated by HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [WAYS-1:0]                      id_valid,
  input  logic [WAYS*ridx_width(NUM_REGS)-1:0] id_rs1,
  input  logic [WAYS*ridx_width(NUM_REGS)-1:0] id_rs2,
  input  logic [WAYS-1:0]                      id_rs1_used,
  input  logic [WAYS-1:0]                      id_rs2_used,
  input  logic [WAYS*ridx_width(NUM_REGS)-1:0] id_dest,
  input  logic [WAYS-1:0]                      id_is_load,
  input  logic                                 stall,
  input  logic                                 flush,
  output logic [WAYS-1:0]                      issue_mask,
  output logic [rollback_width(WAYS)-1:0]      rollback,
  output logic [NUM_REGS-1:0]                  busy_mask,
  output logic [31:0]                          stat_stall_cycles,
  output logic [31:0]                          stat_rollbacks
);

  localparam int RW  = ridx_width(NUM_REGS);
  localparam int RBW = rollback_width(WAYS);
  localparam int CW  = $clog2(LOAD_LAT + 1);

  logic [CW-1:0]   cnt_q [NUM_REGS];
  logic [CW-1:0]   cnt_d [NUM_REGS];
  logic [WAYS-1:0] blocked;
  logic [WAYS-1:0] issue_c;
  logic [RBW-1:0]  rollback_c;
  logic            found;
  logic            open_c;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = (cnt_q[r] != '0);
  end

  for (genvar j = 0; j < WAYS; j++) begin : g_way
    hz_way_check #(
      .WAYS     (WAYS),
      .NUM_REGS (NUM_REGS),
      .WAY      (j)
    ) u_check (
      .valid       (id_valid[j]),
      .rs1         (id_rs1[j*RW +: RW]),
      .rs2         (id_rs2[j*RW +: RW]),
      .rs1_used    (id_rs1_used[j]),
      .rs2_used    (id_rs2_used[j]),
      .busy_mask   (busy_mask),
      .older_valid (id_valid),
      .older_dest  (id_dest),
      .blocked     (blocked[j])
    );
  end

  // Everything from the lowest blocked way upward is refetched.
  always_comb begin
    found      = 1'b0;
    issue_c    = '0;
    rollback_c = '0;
    for (int j = 0; j < WAYS; j++) begin
      if (!found) begin
        if (blocked[j]) begin
          found      = 1'b1;
          rollback_c = RBW'(WAYS - j);
        end else begin
          issue_c[j] = id_valid[j];
        end
      end
    end
  end

  assign open_c     = reset && !stall && !flush;
  assign issue_mask = open_c ? issue_c : '0;
  assign rollback   = open_c ? rollback_c : '0;

  // Ascending way order lets the youngest accepted writer of a register win.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
    end
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
    end else begin
      for (int j = 0; j < WAYS; j++) begin
        if (issue_mask[j] && (id_dest[j*RW +: RW] != '0)) begin
          cnt_d[id_dest[j*RW +: RW]] = id_is_load[j] ? CW'(LOAD_LAT) : '0;
        end
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_rb_q, stat_rb_d;

  always_comb begin
    stat_stall_d = stat_stall_q;
    stat_rb_d    = stat_rb_q;
    if ((rollback != '0) && !stall && !flush && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
    if ((rollback != '0) && (stat_rb_q != '1)) begin
      stat_rb_d = stat_rb_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_stall_q <= '0;
      stat_rb_q    <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_rb_q    <= stat_rb_d;
    end
  end

  assign stat_stall_cycles = stat_stall_q;
  assign stat_rollbacks    = stat_rb_q;
`else
  assign stat_stall_cycles = '0;
  assign stat_rollbacks    = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one LOAD_LAT=1 and one LOAD_LAT=3
// instance share the same stimulus; expectations are hand-computed per cycle.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int W  = 4;
  localparam int NR = 32;
  localparam int RW = 5;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  localparam logic [31:0] EXP_STAT = 32'd5;
`else
  localparam logic [31:0] EXP_STAT = 32'd0;
`endif

  logic            clock;
  logic            reset;
  logic [W-1:0]    id_valid, id_rs1_used, id_rs2_used, id_is_load;
  logic [W*RW-1:0] id_rs1, id_rs2, id_dest;
  logic            stall, flush;

  logic [W-1:0]  issue1, issue3;
  logic [2:0]    rb1, rb3;
  logic [NR-1:0] busy1, busy3;
  logic [31:0]   ss1, sr1, ss3, sr3;

  int checks = 0;
  int passed = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  hazard_scoreboard #(.WAYS(W), .NUM_REGS(NR), .LOAD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_dest(id_dest),
    .id_is_load(id_is_load), .stall(stall), .flush(flush), .issue_mask(issue1),
    .rollback(rb1), .busy_mask(busy1), .stat_stall_cycles(ss1), .stat_rollbacks(sr1)
  );

  hazard_scoreboard #(.WAYS(W), .NUM_REGS(NR), .LOAD_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_dest(id_dest),
    .id_is_load(id_is_load), .stall(stall), .flush(flush), .issue_mask(issue3),
    .rollback(rb3), .busy_mask(busy3), .stat_stall_cycles(ss3), .stat_rollbacks(sr3)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_bundle();
    id_valid = '0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = '0; id_rs2_used = '0;
    id_dest = '0; id_is_load = '0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic set_way(input int w, input ridx_t r1, input logic u1,
                         input ridx_t r2, input logic u2, input ridx_t d, input logic ld);
    id_valid[w]        = 1'b1;
    id_rs1[w*RW +: RW] = r1;
    id_rs1_used[w]     = u1;
    id_rs2[w*RW +: RW] = r2;
    id_rs2_used[w]     = u2;
    id_dest[w*RW +: RW] = d;
    id_is_load[w]      = ld;
  endtask

  task automatic idle_flush();
    @(negedge clock); clear_bundle(); flush = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clock);
    clear_bundle();
    set_way(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    set_way(1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0);
    #1;
    checks++; if (issue1 !== 4'b0000) $display("FAIL rst_issue: got %b want 0000", issue1); else passed++;
    checks++; if (rb1 !== 3'd0) $display("FAIL rst_rollback: got %0d want 0", rb1); else passed++;
    checks++; if (busy1 !== '0 || busy3 !== '0) $display("FAIL rst_busy: got %h/%h want 0", busy1, busy3); else passed++;
    checks++; if (ss3 !== 32'd0 || sr3 !== 32'd0) $display("FAIL rst_stats: got %0d/%0d want 0", ss3, sr3); else passed++;
    @(negedge clock); clear_bundle(); reset = 1'b1;
    #1;
    checks++; if (busy3 !== '0) $display("FAIL rst_release_busy: got %h want 0", busy3); else passed++;
  endtask

  task automatic test_load_use();
    @(negedge clock); clear_bundle();
    set_way(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    checks++; if (issue1 !== 4'b0001) $display("FAIL lu_c0_issue: got %b want 0001", issue1); else passed++;
    @(negedge clock); clear_bundle();
    set_way(0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0);
    set_way(1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0);
    set_way(2, 5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b0);
    set_way(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b0);
    #1;
    checks++; if (issue1 !== 4'b0011) $display("FAIL lu_c1_issue: got %b want 0011", issue1); else passed++;
    checks++; if (rb1 !== 3'd2) $display("FAIL lu_c1_rollback: got %0d want 2", rb1); else passed++;
    checks++; if (busy1[5] !== 1'b1) $display("FAIL lu_c1_busy5: got %b want 1", busy1[5]); else passed++;
    @(negedge clock); #1;
    checks++; if (issue1 !== 4'b1111) $display("FAIL lu_c2_issue: got %b want 1111", issue1); else passed++;
    checks++; if (rb1 !== 3'd0) $display("FAIL lu_c2_rollback: got %0d want 0", rb1); else passed++;
    checks++; if (busy1[5] !== 1'b0) $display("FAIL lu_c2_busy5: got %b want 0", busy1[5]); else passed++;
    idle_flush();
  endtask

  task automatic test_intra_bundle();
    @(negedge clock); clear_bundle();
    set_way(0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);
    set_way(1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd20, 1'b0);
    set_way(2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b0);
    set_way(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b0);
    #1;
    checks++; if (issue1 !== 4'b0001) $display("FAIL ib_raw_issue: got %b want 0001", issue1); else passed++;
    checks++; if (rb1 !== 3'd3) $display("FAIL ib_raw_rollback: got %0d want 3", rb1); else passed++;
    @(negedge clock); clear_bundle();
    set_way(0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    set_way(1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd20, 1'b0);
    set_way(2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b0);
    set_way(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b0);
    #1;
    checks++; if (rb1 !== 3'd0 || issue1 !== 4'b1111) $display("FAIL ib_r0: got %b/%0d want 1111/0", issue1, rb1); else passed++;
    @(negedge clock); clear_bundle();
    set_way(0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);
    set_way(1, 5'd3, 1'b0, 5'd3, 1'b0, 5'd20, 1'b0);
    set_way(2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b0);
    set_way(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b0);
    #1;
    checks++; if (issue1 !== 4'b1111) $display("FAIL ib_unused_src: got %b want 1111", issue1); else passed++;
    @(negedge clock); clear_bundle();
    set_way(0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);
    set_way(1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd20, 1'b0);
    set_way(2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b0);
    set_way(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b0);
    id_valid[0] = 1'b0;
    #1;
    checks++; if (issue1 !== 4'b1110 || rb1 !== 3'd0) $display("FAIL ib_invalid_writer: got %b/%0d want 1110/0", issue1, rb1); else passed++;
    @(negedge clock); clear_bundle();
    set_way(0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);
    set_way(1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd20, 1'b0);
    set_way(2, 5'd3, 1'b1, 5'd0, 1'b0, 5'd21, 1'b0);
    set_way(3, 5'd0, 1'b0, 5'd3, 1'b1, 5'd22, 1'b0);
    id_valid[2] = 1'b0;
    #1;
    checks++; if (issue1 !== 4'b0011 || rb1 !== 3'd1) $display("FAIL ib_last_way: got %b/%0d want 0011/1", issue1, rb1); else passed++;
  endtask

  task automatic test_stall_latency();
    @(negedge clock); clear_bundle();
    set_way(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    checks++; if (issue3 !== 4'b0001) $display("FAIL sl_c0_issue: got %b want 0001", issue3); else passed++;
    @(negedge clock); clear_bundle(); stall = 1'b1;
    set_way(0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
    #1;
    checks++; if (issue3 !== 4'b0000 || rb3 !== 3'd0) $display("FAIL sl_c1_stall: got %b/%0d want 0000/0", issue3, rb3); else passed++;
    checks++; if (busy3[7] !== 1'b1) $display("FAIL sl_c1_busy7: got %b want 1", busy3[7]); else passed++;
    @(negedge clock); #1;
    checks++; if (busy3[7] !== 1'b1) $display("FAIL sl_c2_busy7: got %b want 1", busy3[7]); else passed++;
    checks++; if (busy1[7] !== 1'b0) $display("FAIL sl_c2_lat1_busy7: got %b want 0", busy1[7]); else passed++;
    @(negedge clock); stall = 1'b0; #1;
    checks++; if (issue3 !== 4'b0000 || rb3 !== 3'd4) $display("FAIL sl_c3_blocked: got %b/%0d want 0000/4", issue3, rb3); else passed++;
    checks++; if (busy3[7] !== 1'b1) $display("FAIL sl_c3_busy7: got %b want 1", busy3[7]); else passed++;
    @(negedge clock); #1;
    checks++; if (issue3 !== 4'b0001 || rb3 !== 3'd0) $display("FAIL sl_c4_issue: got %b/%0d want 0001/0", issue3, rb3); else passed++;
    checks++; if (busy3[7] !== 1'b0) $display("FAIL sl_c4_busy7: got %b want 0", busy3[7]); else passed++;
  endtask

  task automatic test_same_reg_writers();
    @(negedge clock); clear_bundle();
    set_way(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    set_way(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0);
    #1;
    checks++; if (issue1 !== 4'b1010) $display("FAIL sw_issue: got %b want 1010", issue1); else passed++;
    @(negedge clock); clear_bundle();
    set_way(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0);
    set_way(3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    #1;
    checks++; if (busy1[9] !== 1'b0 || busy3[9] !== 1'b0) $display("FAIL sw_alu_last: got %b/%b want 0/0", busy1[9], busy3[9]); else passed++;
    @(negedge clock); clear_bundle(); #1;
    checks++; if (busy1[9] !== 1'b1 || busy3[9] !== 1'b1) $display("FAIL sw_load_last: got %b/%b want 1/1", busy1[9], busy3[9]); else passed++;
    @(negedge clock); #1;
    checks++; if (busy1[9] !== 1'b0 || busy3[9] !== 1'b1) $display("FAIL sw_decay: got %b/%b want 0/1", busy1[9], busy3[9]); else passed++;
    idle_flush();
  endtask

  task automatic test_flush_and_reset();
    @(negedge clock); clear_bundle();
    set_way(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    @(negedge clock); clear_bundle(); flush = 1'b1;
    set_way(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0);
    #1;
    checks++; if (busy3[4] !== 1'b1) $display("FAIL fl_busy_before: got %b want 1", busy3[4]); else passed++;
    checks++; if (issue1 !== 4'b0000 || rb1 !== 3'd0) $display("FAIL fl_gate: got %b/%0d want 0000/0", issue1, rb1); else passed++;
    @(negedge clock); clear_bundle(); #1;
    checks++; if (busy1 !== '0 || busy3 !== '0) $display("FAIL fl_cleared: got %h/%h want 0", busy1, busy3); else passed++;
    @(negedge clock); clear_bundle();
    set_way(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    @(negedge clock); clear_bundle();
    set_way(0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd2, 1'b0);
    #1;
    checks++; if (busy3[4] !== 1'b1) $display("FAIL rm_busy_before: got %b want 1", busy3[4]); else passed++;
    #1 reset = 1'b0;
    #1;
    checks++; if (busy1 !== '0 || busy3 !== '0) $display("FAIL rm_busy: got %h/%h want 0", busy1, busy3); else passed++;
    checks++; if (issue3 !== 4'b0000 || rb3 !== 3'd0) $display("FAIL rm_outputs: got %b/%0d want 0000/0", issue3, rb3); else passed++;
    @(negedge clock); clear_bundle(); reset = 1'b1;
  endtask

  task automatic test_stats();
    @(negedge clock); clear_bundle(); #1;
    checks++; if (sr3 !== 32'd0) $display("FAIL st_start: got %0d want 0", sr3); else passed++;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock); clear_bundle();
      set_way(0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);
      set_way(1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd20, 1'b0);
      if (k == 5) stall = 1'b1;
      if (k == 6) flush = 1'b1;
    end
    @(negedge clock); clear_bundle(); #1;
    checks++; if (sr1 !== EXP_STAT || sr3 !== EXP_STAT) $display("FAIL st_rollbacks: got %0d/%0d want %0d", sr1, sr3, EXP_STAT); else passed++;
    checks++; if (ss1 !== EXP_STAT || ss3 !== EXP_STAT) $display("FAIL st_stall_cycles: got %0d/%0d want %0d", ss1, ss3, EXP_STAT); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    clear_bundle();
    test_reset();
    test_load_use();
    test_intra_bundle();
    test_stall_latency();
    test_same_reg_writers();
    test_flush_and_reset();
    test_stats();
    @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter WAYS, default 4, meaning issue width (>=2).
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning architectural register count; register index width is $clog2(NUM_REGS).
REQ-003 SHALL have parameter LOAD_LAT, default 1, meaning cycles a load result is unavailable to later readers (1..7).
REQ-004 SHALL have ports:
 clock  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low
 id_valid  in  WAYS  way holds an instruction
 id_rs1, id_rs2  in  WAYS x RIDX  source indices
 id_rs1_used, id_rs2_used  in  WAYS  source actually read
 id_dest  in  WAYS x RIDX  destination index
 id_is_load  in  WAYS  way is a load
 stall  in  1  downstream not accepting this cycle
 flush  in  1  squash of all in-flight work
 issue_mask  out  WAYS  ways accepted this cycle
 rollback  out  ROLLBACK_WIDTH  youngest ways to refetch (0..WAYS)
 busy_mask  out  NUM_REGS  registers with pending load
 stat_stall_cycles, stat_rollbacks  out  32  performance counters

Function
REQ-005 SHALL keep one counter per register (width $clog2(LOAD_LAT+1)); register is busy when counter != 0; busy_mask reflects counters combinationally.
REQ-006 Register 0 SHALL never be tracked, never busy, never cause a dependency.
REQ-007 Way j SHALL be blocked if valid and a used source (nonzero) is busy, or equals nonzero id_dest of any valid earlier way i<j.
REQ-008 With f = lowest blocked way index: rollback = WAYS-f, else 0; issue_mask = id_valid restricted to ways below f.
REQ-009 When stall or flush is high: issue_mask = 0, rollback = 0, no counter set.
REQ-010 Each accepted load with dest d != 0 SHALL load counter[d] = LOAD_LAT at the clock edge; all other nonzero counters decrement by 1 per edge.
REQ-011 Accepted non-load writer of d SHALL clear counter[d] at the edge; among accepted writers of one register, the highest way index decides.
REQ-012 Set/clear for register d SHALL take priority over decrement of d in the same cycle.
REQ-013 Decrement SHALL continue during stall.
REQ-014 flush SHALL clear all counters at the next edge.
REQ-015 Dependence latency: load accepted in cycle t, reader of its dest blocked in t+1..t+LOAD_LAT, issuable in t+LOAD_LAT+1.
REQ-016 issue_mask, rollback SHALL be combinational from inputs and state (zero latency); counter updates take effect next cycle.

Reset
REQ-017 While reset is low: all counters 0, busy_mask 0, issue_mask 0, rollback 0, stat counters 0, regardless of other inputs.
REQ-018 Reset asserted mid-operation SHALL discard all pending load state immediately (asynchronous).

Configuration
REQ-019 Macro HAZARD_SCOREBOARD_STATS_EN defined: stat_stall_cycles increments each cycle stall=0, flush=0 and rollback!=0; stat_rollbacks increments each cycle rollback!=0; both saturate at 2^32-1.
REQ-020 Macro undefined: no stat registers; both stat outputs tied to 0.

Structure
REQ-021 ROLLBACK_WIDTH ($clog2(WAYS+1)) and the register-index typedef SHALL live in the shared pipeline package.
REQ-022 One sub-module hz_way_check SHALL evaluate REQ-007 for one way (instantiated WAYS times); counters and stats stay in the top.

Verification
REQ-023 WAYS=4, LOAD_LAT=1: cycle0 way0 load r5 accepted; cycle1 way2 reads r5 -> issue_mask=0011, rollback=2; cycle2 same bundle -> issue_mask=1111, rollback=0.
REQ-024 Same bundle: way0 writes r3, way1 reads r3 -> rollback=3, issue_mask=0001; way0 dest r0, way1 reads r0 -> rollback=0.
REQ-025 LOAD_LAT=3: load r7 accepted cycle0, stall high cycle1-2 -> reader of r7 blocked cycle1-3, accepted cycle4; busy_mask[7] clear from cycle4.
REQ-026 Load r9 way1 and ALU write r9 way3 accepted same cycle -> busy_mask[9]=0 next cycle; reversed order -> busy_mask[9]=1.
REQ-027 Load r4 accepted, flush next cycle -> busy_mask=0 following cycle; reset low during pending load -> all outputs 0 immediately.
REQ-028 With HAZARD_SCOREBOARD_STATS_EN: 5 rollback cycles -> stat_rollbacks=5, stat_stall_cycles=5; without macro both stay 0.
